vm_coin_acceptor: RTL and testbench
===================================

Name: vm_coin_acceptor

Overview:
Front-end stage of the vending machine. It conditions the two raw coin-slot sensors (5-unit and 10-unit) and produces the 2-bit coin code consumed directly by the vending FSM. The code is one clean, single-cycle pulse per physical coin. The block also rejects glitches, double-sensor faults and coins arriving while acceptance is disabled, flags jams, and keeps saturating accept/reject statistics.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable synced samples needed to validate a coin (legal range >= 2)
RELEASE_CYCLES, 3, consecutive cycles with both sensors low before a new coin is armed (>= 1)
JAM_CYCLES, 20, cycles a sensor may stay high after validation before jam is flagged (> DEBOUNCE_CYCLES)
CNT_W, 8, width of the statistics counters

Ports:
clk  in  1  clock; all logic on the rising edge
rst  in  1  reset, synchronous, active-high
coin5_raw  in  1  asynchronous 5-unit slot sensor, high while a coin is present
coin10_raw  in  1  asynchronous 10-unit slot sensor
accept_en  in  1  1 = coins accepted; 0 = valid coins are routed to reject
coin_code  out  2  00 none, 01 = 5 units, 10 = 10 units; 11 is never driven
reject  out  1  one-cycle pulse per rejected coin
jam  out  1  level; high while a jam condition persists
busy  out  1  high whenever FSM is not in IDLE
accept_cnt  out  CNT_W  count of coins output on coin_code, saturating
reject_cnt  out  CNT_W  count of reject pulses, saturating

Behaviour:
- Reset values: coin_code=00, reject=0, jam=0, accept_cnt=0, reject_cnt=0, sync flops=0, FSM=WAIT_RELEASE, all counters=0. busy is therefore 1 out of reset.
- Each raw sensor passes through a 2-flop synchronizer; s5/s10 denote the synced values. The FSM uses only s5/s10.
- All outputs are registered. coin_code and reject are high for exactly one cycle per event and are never both high.
- IDLE:
  - exactly one of s5/s10 high: latch kind, set debounce count=1, go to DEBOUNCE.
  - both high: pulse reject, go to WAIT_RELEASE.
  - neither high: stay in IDLE.
- DEBOUNCE:
  - latched sensor high and other sensor low: count+1. When the count reaches DEBOUNCE_CYCLES, register the result:
    - accept_en sampled at that same edge is 1: coin_code=kind, accept_cnt+1.
    - accept_en is 0: reject=1, reject_cnt+1.
    - In both cases go to WAIT_RELEASE.
  - latched sensor drops: treat as a glitch; no output, return to IDLE.
  - other sensor rises: pulse reject, go to WAIT_RELEASE.
- Latency: number edges from the first one that samples raw high as edge 1. The output is registered at edge DEBOUNCE_CYCLES+2 and is visible during the following cycle (edge 6 with the defaults).
- WAIT_RELEASE:
  - Release counter counts consecutive cycles with s5=s10=0 and resets to 0 on any high sample. When it reaches RELEASE_CYCLES, go to IDLE.
  - Hold counter counts cycles since entry while any sensor is high. When it reaches JAM_CYCLES, set jam=1 and go to JAM.
- JAM: jam stays 1. Once RELEASE_CYCLES consecutive low cycles are seen, clear jam and go to IDLE. No codes or rejects are issued while in JAM.
- Coin handling: no coin can produce more than one coin_code or reject, including coins held indefinitely.
- Saturation: accept_cnt and reject_cnt hold at all-ones and never wrap.
- Reset mid-operation: any in-flight coin is discarded. A sensor still high after reset is not counted until it is released and a new insertion occurs.
- Simultaneous events: a rising other-sensor in the validation cycle takes priority; the result is a reject, not a coin.

Decomposition:
- Shared package vm_pkg:
  - coin-code constants COIN_NONE=2'b00, COIN_5=2'b01, COIN_10=2'b10; the downstream vending FSM uses the same constants.
  - acceptor state encoding IDLE, DEBOUNCE, WAIT_RELEASE, JAM.
- One sub-module, vm_sync_2ff: a single-bit 2-flop synchronizer with synchronous reset, instantiated twice.
- The internal counter width is $clog2 of the largest of DEBOUNCE_CYCLES, RELEASE_CYCLES and JAM_CYCLES, plus 1.

Test Plan:
All scenarios use default parameters and start after reset with sensors idle for 5 cycles.
- Clean 5-unit coin: coin5_raw high 10 cycles, accept_en=1 -> coin_code=01 for exactly one cycle, registered at edge 6; accept_cnt=1; reject never high.
- Glitch: coin10_raw high for 2 cycles -> coin_code stays 00, reject=0, both counts unchanged, FSM back in IDLE.
- Double sensor: coin5_raw and coin10_raw rise together and stay high 8 cycles -> one reject pulse; reject_cnt=1; no coin_code.
- Disabled: accept_en=0, coin10_raw high 10 cycles -> one reject pulse at edge 6; coin_code stays 00.
- Jam: coin5_raw held 40 cycles -> a single coin_code=01; jam rises while the sensor is still held; after release, jam clears 3 cycles after the sensors go low; a following 10-unit coin yields coin_code=10.
- Reset mid-debounce: coin10_raw high, rst pulsed at edge 4 while the sensor stays high 10 more cycles -> no coin_code; a later fresh coin10 insertion is accepted normally.

Source files
------------

// File: rtl/vm_pkg.sv
// vm_pkg: coin codes and acceptor state encoding shared across the vending machine
package vm_pkg;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, WAIT_RELEASE, JAM} acc_state_e;
endpackage

// File: rtl/vm_sync_2ff.sv
// vm_sync_2ff: two-flop synchronizer for one asynchronous bit
module vm_sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    // shift the raw bit through two flops
    always_ff @(posedge clk)
        if (rst) {sync_q, meta_q} <= 2'b00;
        else     {sync_q, meta_q} <= {meta_q, d};
    assign q = sync_q;
endmodule

// File: rtl/vm_coin_acceptor.sv
// vm_coin_acceptor: conditions two coin sensors into one-pulse coin codes, rejects, jam flag and stats
module vm_coin_acceptor
    import vm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 3,
    parameter int JAM_CYCLES      = 20,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin5_raw,
    input  logic             coin10_raw,
    input  logic             accept_en,
    output logic [1:0]       coin_code,
    output logic             reject,
    output logic             jam,
    output logic             busy,
    output logic [CNT_W-1:0] accept_cnt,
    output logic [CNT_W-1:0] reject_cnt
);
    localparam int MAXC = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ?
                          ((DEBOUNCE_CYCLES > JAM_CYCLES) ? DEBOUNCE_CYCLES : JAM_CYCLES) :
                          ((RELEASE_CYCLES > JAM_CYCLES) ? RELEASE_CYCLES : JAM_CYCLES);
    localparam int CW = $clog2(MAXC) + 1;

    logic s5, s10, any_s, mine_s, other_s;
    acc_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, rel_q, rel_d, rel_inc;
    logic [1:0] kind_q, kind_d, code_q, code_d;
    logic rej_q, rej_d, jam_q, jam_d;
    logic [CNT_W-1:0] acc_q, acc_d, rcnt_q, rcnt_d;

    vm_sync_2ff u_sync5  (.clk(clk), .rst(rst), .d(coin5_raw),  .q(s5));
    vm_sync_2ff u_sync10 (.clk(clk), .rst(rst), .d(coin10_raw), .q(s10));

    assign any_s   = s5 | s10;
    assign mine_s  = (kind_q == COIN_5) ? s5 : s10;
    assign other_s = (kind_q == COIN_5) ? s10 : s5;
    assign rel_inc = any_s ? '0 : rel_q + 1'b1;

    // next state, counters and one-cycle result pulses
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rel_d   = rel_q;
        kind_d  = kind_q;
        code_d  = COIN_NONE;
        rej_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s5 && s10) begin
                    rej_d   = 1'b1;
                    cnt_d   = '0;
                    rel_d   = '0;
                    state_d = WAIT_RELEASE;
                end else if (any_s) begin
                    kind_d  = s5 ? COIN_5 : COIN_10;
                    cnt_d   = CW'(1);
                    state_d = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (other_s || (mine_s && cnt_q + 1'b1 == CW'(DEBOUNCE_CYCLES))) begin
                    code_d  = (!other_s && accept_en) ? kind_q : COIN_NONE;
                    rej_d   = other_s || !accept_en;
                    cnt_d   = '0;
                    rel_d   = '0;
                    state_d = WAIT_RELEASE;
                end else if (!mine_s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_RELEASE: begin
                rel_d = rel_inc;
                cnt_d = cnt_q + CW'(any_s);
                if (rel_inc == CW'(RELEASE_CYCLES)) state_d = IDLE;
                else if (cnt_d == CW'(JAM_CYCLES)) state_d = JAM;
            end
            JAM: begin
                rel_d = rel_inc;
                if (rel_inc == CW'(RELEASE_CYCLES)) state_d = IDLE;
            end
            default: state_d = WAIT_RELEASE;
        endcase
        jam_d  = state_d == JAM;
        acc_d  = (code_d != COIN_NONE && acc_q != '1) ? acc_q + 1'b1 : acc_q;
        rcnt_d = (rej_d && rcnt_q != '1) ? rcnt_q + 1'b1 : rcnt_q;
    end

    // state and registered outputs; reset parks in WAIT_RELEASE so a held coin is ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_RELEASE;
            cnt_q   <= '0;
            rel_q   <= '0;
            kind_q  <= COIN_NONE;
            code_q  <= COIN_NONE;
            rej_q   <= 1'b0;
            jam_q   <= 1'b0;
            acc_q   <= '0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rel_q   <= rel_d;
            kind_q  <= kind_d;
            code_q  <= code_d;
            rej_q   <= rej_d;
            jam_q   <= jam_d;
            acc_q   <= acc_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign coin_code  = code_q;
    assign reject     = rej_q;
    assign jam        = jam_q;
    assign busy       = state_q != IDLE;
    assign accept_cnt = acc_q;
    assign reject_cnt = rcnt_q;
endmodule

// File: tb/tb_vm_coin_acceptor.sv
// tb_vm_coin_acceptor: directed and random coin traffic checked against a behavioural model every cycle
module tb_vm_coin_acceptor;
    logic clk = 1'b0, rst = 1'b1, coin5_raw = 1'b0, coin10_raw = 1'b0, accept_en = 1'b1;
    logic [1:0] coin_code;
    logic reject, jam, busy;
    logic [7:0] accept_cnt, reject_cnt;
    int n_chk = 0, n_pass = 0;
    bit chk_on = 1'b0;

    vm_coin_acceptor dut (
        .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
        .accept_en(accept_en), .coin_code(coin_code), .reject(reject), .jam(jam),
        .busy(busy), .accept_cnt(accept_cnt), .reject_cnt(reject_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    // Model: a coin is "armed" once the synced sensors have been low for 3 cycles;
    // an armed coin of one kind must stay alone for 4 synced samples to count.
    bit d1_5, d2_5, d1_10, d2_10;
    bit armed, jammed;
    int kind, stable, lowrun, held;
    int e_code, e_acc, e_rcnt;
    bit e_rej;

    function automatic void disarm();
        armed = 0; kind = 0; lowrun = 0; held = 0;
    endfunction

    function automatic void do_reject();
        e_rej = 1;
        if (e_rcnt < 255) e_rcnt++;
    endfunction

    always @(posedge clk) begin
        bit c5, c10, any, mine, oth;
        c5 = d2_5; c10 = d2_10;
        d2_5 = d1_5; d1_5 = coin5_raw;
        d2_10 = d1_10; d1_10 = coin10_raw;
        e_code = 0; e_rej = 0;
        if (rst) begin
            d1_5 = 0; d2_5 = 0; d1_10 = 0; d2_10 = 0;
            disarm(); jammed = 0; e_acc = 0; e_rcnt = 0;
        end else begin
            any = c5 || c10;
            if (armed && kind == 0) begin
                if (c5 && c10) begin do_reject(); disarm(); end
                else if (any) begin kind = c5 ? 5 : 10; stable = 1; end
            end else if (armed) begin
                mine = (kind == 5) ? c5 : c10;
                oth  = (kind == 5) ? c10 : c5;
                if (oth) begin do_reject(); disarm(); end
                else if (!mine) kind = 0;
                else begin
                    stable++;
                    if (stable == 4) begin
                        if (accept_en) begin
                            e_code = (kind == 5) ? 1 : 2;
                            if (e_acc < 255) e_acc++;
                        end else do_reject();
                        disarm();
                    end
                end
            end else begin
                lowrun = any ? 0 : lowrun + 1;
                if (!jammed && any) held++;
                if (lowrun == 3) begin armed = 1; kind = 0; jammed = 0; end
                else if (!jammed && held == 20) jammed = 1;
            end
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("coin_code", 32'(coin_code), 32'(e_code));
        check("reject", 32'(reject), 32'(e_rej));
        check("excl", 32'(coin_code != 2'b00 && reject), 32'd0);
        check("jam", 32'(jam), 32'(jammed));
        check("busy", 32'(busy), 32'(!(armed && kind == 0)));
        check("accept_cnt", 32'(accept_cnt), 32'(e_acc));
        check("reject_cnt", 32'(reject_cnt), 32'(e_rcnt));
    end

    task automatic drive(input bit c5, input bit c10, input bit en, input int n);
        coin5_raw = c5; coin10_raw = c10; accept_en = en;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        rst = 1'b0;
        drive(0, 0, 1, 5);
        drive(1, 0, 1, 10); drive(0, 0, 1, 6);
        drive(0, 1, 1, 2);  drive(0, 0, 1, 6);
        drive(1, 1, 1, 8);  drive(0, 0, 1, 6);
        drive(0, 1, 0, 10); drive(0, 0, 1, 6);
        drive(1, 0, 1, 40); drive(0, 0, 1, 6);
        drive(0, 1, 1, 10); drive(0, 0, 1, 6);
        drive(0, 1, 1, 3);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        drive(0, 1, 1, 10); drive(0, 0, 1, 6);
        drive(0, 1, 1, 10); drive(0, 0, 1, 6);
        for (int i = 0; i < 262; i++) begin drive(1, 0, 1, 5); drive(0, 0, 1, 4); end
        for (int i = 0; i < 262; i++) begin drive(1, 1, 1, 1); drive(0, 0, 1, 4); end
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        drive(0, 0, 1, 5);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1; @(negedge clk); rst = 1'b0;
            end
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), $urandom_range(1, 28));
            drive(0, 0, 1'($urandom_range(0, 1)), $urandom_range(1, 6));
        end
        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
